// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader and the stack CPU it feeds.
// Holds the loader FSM state encoding, the maximum program length and the
// reserved top-of-memory addresses that the CPU uses for error/result/x.
package program_loader_pkg;

    localparam int unsigned ProgMax = 253;

    // Reserved addresses above the program area, shared with the CPU.
    localparam logic [7:0] AddrErr    = 8'd253;
    localparam logic [7:0] AddrResult = 8'd254;
    localparam logic [7:0] AddrX      = 8'd255;

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StLen  = 3'd1;
    localparam logic [2:0] StData = 3'd2;
    localparam logic [2:0] StCsum = 3'd3;
    localparam logic [2:0] StDone = 3'd4;
    localparam logic [2:0] StErr  = 3'd5;

endpackage

// File: rtl/program_loader.sv
// Program loader: receives a framed program image (LEN, N bytes, CSUM) over a
// valid/ready byte stream, writes the bytes into CPU memory from address 0,
// checks that LEN + bytes + CSUM sums to zero mod 256 and then releases the CPU.
//
// Ports:
//   clock      system clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   load_req   1-cycle pulse that starts or restarts a load
//   in_data    stream byte
//   in_valid   in_data is valid
//   in_ready   loader accepts a byte this cycle (depends on state only)
//   mem_we     memory write strobe, one cycle per program byte
//   mem_addr   memory write address
//   mem_wdata  memory write data
//   cpu_start  high keeps the CPU in start/init, low lets it run
//   load_done  frame loaded with a good checksum
//   load_err   bad length or bad checksum
//   csum       running 8-bit sum of accepted bytes
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned PROG_MAX = ProgMax
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_start,
    output logic              load_done,
    output logic              load_err,
    output logic [DATA_W-1:0] csum
);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [DATA_W-1:0] csum_q, csum_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              accept;
    logic [DATA_W-1:0] csum_next;

    assign in_ready  = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
    assign accept    = in_valid & in_ready;
    assign csum_next = csum_q + in_data;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        csum_d      = csum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        if (load_req) begin
            // Restart wins over any byte accepted in the same cycle.
            state_d    = StLen;
            cnt_d      = '0;
            csum_d     = '0;
            mem_addr_d = '0;
        end else begin
            case (state_q)
                StLen: begin
                    if (accept) begin
                        if (in_data == '0 || in_data > DATA_W'(PROG_MAX)) begin
                            state_d = StErr;
                        end else begin
                            len_d   = ADDR_W'(in_data);
                            csum_d  = in_data;
                            state_d = StData;
                        end
                    end
                end
                StData: begin
                    if (accept) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = cnt_q;
                        mem_wdata_d = in_data;
                        cnt_d       = cnt_q + ADDR_W'(1);
                        csum_d      = csum_next;
                        if (cnt_d == len_q) begin
                            state_d = StCsum;
                        end
                    end
                end
                StCsum: begin
                    if (accept) begin
                        csum_d  = csum_next;
                        state_d = (csum_next == '0) ? StDone : StErr;
                    end
                end
                StIdle, StDone, StErr: begin
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            len_q       <= '0;
            csum_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            csum_q      <= csum_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign csum      = csum_q;
    assign cpu_start = (state_q != StDone);
    assign load_done = (state_q == StDone);
    assign load_err  = (state_q == StErr);

endmodule
